// File: rtl/apb_completer_regfile.sv
// APB3 completer with a small 16-bit register file and programmable wait states.
// Optional PSLVERR output is enabled by defining APB_COMPLETER_PSLVERR_EN.
module apb_completer_regfile #(
  parameter int          NUM_REGS = 8,
  parameter logic [15:0] ID_VALUE = 16'hA5B0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [15:0]              PADDR,
  input  logic [15:0]              PWDATA,
  output logic [15:0]              PRDATA,
  output logic                     PREADY,
  input  logic [3:0]               wait_states,
  output logic [NUM_REGS*16-1:0]   regs_o,
  output logic                     prot_err
`ifdef APB_COMPLETER_PSLVERR_EN
  ,
  output logic                     PSLVERR
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] prdata_q, prdata_d;
  logic        write_q, write_d;
  logic        pready_q, pready_d;
  logic        prot_err_q, prot_err_d;
  logic        wr_en;

  logic [15:0] reg_q [1:NUM_REGS-1];

  // In IDLE a zero-wait transfer completes off the live bus; otherwise off the latched copy.
  logic [15:0] rd_addr;
  logic        rd_write;
  logic [15:0] rd_data;

  assign rd_addr  = (state_q == S_IDLE) ? PADDR  : addr_q;
  assign rd_write = (state_q == S_IDLE) ? PWRITE : write_q;

  always_comb begin
    rd_data = 16'h0000;
    if (rd_addr == 16'h0000) begin
      rd_data = ID_VALUE;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_addr == 16'(i)) begin
        rd_data = reg_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    prot_err_d = prot_err_q;
    pready_d   = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = wait_states;
          if (wait_states == 4'd0) begin
            state_d  = S_DONE;
            pready_d = 1'b1;
            if (!rd_write) begin
              prdata_d = rd_data;
            end
          end else begin
            state_d = S_WAIT;
          end
        end else if (PSEL && PENABLE) begin
          prot_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!PSEL || !PENABLE) begin
          prot_err_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = S_DONE;
            pready_d = 1'b1;
            if (!rd_write) begin
              prdata_d = rd_data;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (PSEL && PENABLE) begin
          wr_en = write_q && (addr_q != 16'h0000) && (addr_q < 16'(NUM_REGS));
        end else begin
          prot_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 16'h0000;
      write_q    <= 1'b0;
      wdata_q    <= 16'h0000;
      prdata_q   <= 16'h0000;
      pready_q   <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      prot_err_q <= prot_err_d;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        reg_q[i] <= 16'h0000;
      end
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (addr_q == 16'(i)) begin
          reg_q[i] <= wdata_q;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    if (gi == 0) begin : g_id
      assign regs_o[15:0] = ID_VALUE;
    end else begin : g_rw
      assign regs_o[16*gi +: 16] = reg_q[gi];
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign prot_err = prot_err_q;

`ifdef APB_COMPLETER_PSLVERR_EN
  logic slverr_q;
  logic addr_ok;

  assign addr_ok = rd_addr < 16'(NUM_REGS);

  // Raised only alongside PREADY, so it clears automatically when DONE is left.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      slverr_q <= 1'b0;
    end else begin
      slverr_q <= pready_d && (!addr_ok || (rd_write && (rd_addr == 16'h0000)));
    end
  end

  assign PSLVERR = slverr_q;
`endif

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile: each test task drives a scenario and checks inline.
module tb_apb_completer_regfile;

  localparam int NR = 8;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic            PSEL, PENABLE, PWRITE;
  logic [15:0]     PADDR, PWDATA;
  logic [15:0]     PRDATA;
  logic            PREADY;
  logic [3:0]      wait_states;
  logic [NR*16-1:0] regs_o;
  logic            prot_err;
`ifdef APB_COMPLETER_PSLVERR_EN
  logic            PSLVERR;
`endif

  int n_cmp = 0;
  int n_err = 0;

  apb_completer_regfile #(.NUM_REGS(NR), .ID_VALUE(16'hA5B0)) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .wait_states (wait_states),
    .regs_o      (regs_o),
    .prot_err    (prot_err)
`ifdef APB_COMPLETER_PSLVERR_EN
    ,
    .PSLVERR     (PSLVERR)
`endif
  );

  always #5 PCLK = ~PCLK;

  // Stimulus only: runs one transfer starting just after a rising edge and reports
  // the access cycle in which PREADY was seen (-1 on timeout), read data and PSLVERR.
  task automatic do_xfer(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                         input logic [3:0] ws, output int lat, output logic [15:0] rd,
                         output logic err);
    lat = -1;
    rd  = 16'hxxxx;
    err = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; wait_states = ws;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    wait_states = ~ws;
    PADDR  = ~addr;
    PWDATA = ~data;
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        lat = k;
        rd  = PRDATA;
`ifdef APB_COMPLETER_PSLVERR_EN
        err = PSLVERR;
`endif
        break;
      end
      @(posedge PCLK); #1;
    end
    if (lat > 0) begin
      @(posedge PCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("xfer wr=%0b addr=%0h wdata=%0h ws=%0d -> lat=%0d rdata=%0h err=%0b",
             wr, addr, data, ws, lat, rd, err);
  endtask

  task automatic test_reset;
    PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; wait_states = 0;
    repeat (3) @(posedge PCLK);
    #1;
    n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL reset_pready got=%0b exp=0", PREADY); end
    n_cmp++; if (PRDATA !== 16'h0) begin n_err++; $display("FAIL reset_prdata got=%h exp=0000", PRDATA); end
    n_cmp++; if (regs_o[15:0] !== 16'hA5B0) begin n_err++; $display("FAIL reset_id got=%h exp=a5b0", regs_o[15:0]); end
    n_cmp++; if (regs_o[NR*16-1:16] !== '0) begin n_err++; $display("FAIL reset_regs got=%h exp=0", regs_o[NR*16-1:16]); end
    n_cmp++; if (prot_err !== 1'b0) begin n_err++; $display("FAIL reset_prot_err got=%0b exp=0", prot_err); end
    PRESET = 1'b0;
    $display("reset released");
  endtask

  task automatic test_zero_wait;
    int lat; logic [15:0] rd; logic err;
    do_xfer(1'b1, 16'd3, 16'h1234, 4'd0, lat, rd, err);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL zw_write_lat got=%0d exp=1", lat); end
    n_cmp++; if (regs_o[63:48] !== 16'h1234) begin n_err++; $display("FAIL zw_reg3 got=%h exp=1234", regs_o[63:48]); end
    do_xfer(1'b0, 16'd3, 16'h0000, 4'd0, lat, rd, err);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL zw_read_lat got=%0d exp=1", lat); end
    n_cmp++; if (rd !== 16'h1234) begin n_err++; $display("FAIL zw_read_data got=%h exp=1234", rd); end
  endtask

  task automatic test_wait_states;
    int lat; logic [15:0] rd; logic err;
    do_xfer(1'b0, 16'd0, 16'h0000, 4'd5, lat, rd, err);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL ws5_lat got=%0d exp=6", lat); end
    n_cmp++; if (rd !== 16'hA5B0) begin n_err++; $display("FAIL ws5_data got=%h exp=a5b0", rd); end
    do_xfer(1'b0, 16'd3, 16'h0000, 4'd1, lat, rd, err);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL ws1_lat got=%0d exp=2", lat); end
    n_cmp++; if (rd !== 16'h1234) begin n_err++; $display("FAIL ws1_data got=%h exp=1234", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rd; logic err;
    do_xfer(1'b1, 16'd5, 16'hBEEF, 4'd2, lat, rd, err);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL b2b_wr_lat got=%0d exp=3", lat); end
    do_xfer(1'b0, 16'd5, 16'h0000, 4'd0, lat, rd, err);
    n_cmp++; if (rd !== 16'hBEEF) begin n_err++; $display("FAIL b2b_rd5 got=%h exp=beef", rd); end
    do_xfer(1'b1, 16'd7, 16'hAAAA, 4'd0, lat, rd, err);
    do_xfer(1'b0, 16'd7, 16'h0000, 4'd3, lat, rd, err);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL b2b_rd7_lat got=%0d exp=4", lat); end
    n_cmp++; if (rd !== 16'hAAAA) begin n_err++; $display("FAIL b2b_rd7 got=%h exp=aaaa", rd); end
  endtask

  task automatic test_illegal;
    int lat; logic [15:0] rd; logic err;
    logic [NR*16-1:0] exp_regs;
    exp_regs = '0;
    exp_regs[15:0]    = 16'hA5B0;
    exp_regs[63:48]   = 16'h1234;
    exp_regs[95:80]   = 16'hBEEF;
    exp_regs[127:112] = 16'hAAAA;
    do_xfer(1'b1, 16'd0, 16'hFFFF, 4'd0, lat, rd, err);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL ill_w0_lat got=%0d exp=1", lat); end
`ifdef APB_COMPLETER_PSLVERR_EN
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_w0_slverr got=%0b exp=1", err); end
`endif
    do_xfer(1'b1, 16'd20, 16'hFFFF, 4'd1, lat, rd, err);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL ill_w20_lat got=%0d exp=2", lat); end
`ifdef APB_COMPLETER_PSLVERR_EN
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_w20_slverr got=%0b exp=1", err); end
`endif
    n_cmp++; if (regs_o !== exp_regs) begin n_err++; $display("FAIL ill_regs got=%h exp=%h", regs_o, exp_regs); end
    do_xfer(1'b0, 16'd20, 16'h0000, 4'd0, lat, rd, err);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL ill_rd20 got=%h exp=0000", rd); end
    do_xfer(1'b0, 16'd7, 16'h0000, 4'd0, lat, rd, err);
`ifdef APB_COMPLETER_PSLVERR_EN
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL legal_slverr got=%0b exp=0", err); end
`endif
    do_xfer(1'b0, 16'd8, 16'h0000, 4'd2, lat, rd, err);
    n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL ill_rd8 got=%h exp=0000", rd); end
    // PENABLE without PSEL in IDLE must be ignored.
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PENABLE = 1'b0;
    n_cmp++; if (prot_err !== 1'b0) begin n_err++; $display("FAIL idle_penable_prot got=%0b exp=0", prot_err); end
  endtask

  task automatic test_abort;
    int lat; logic [15:0] rd; logic err;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'd2; PWDATA = 16'h5555; wait_states = 4'd4;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    $display("abort write idx2 with PSEL dropped in second wait cycle");
    n_cmp++; if (prot_err !== 1'b1) begin n_err++; $display("FAIL abort_prot got=%0b exp=1", prot_err); end
    n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL abort_pready got=%0b exp=0", PREADY); end
    n_cmp++; if (regs_o[47:32] !== 16'h0000) begin n_err++; $display("FAIL abort_reg2 got=%h exp=0000", regs_o[47:32]); end
    do_xfer(1'b1, 16'd2, 16'h7777, 4'd1, lat, rd, err);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL post_abort_lat got=%0d exp=2", lat); end
    do_xfer(1'b0, 16'd2, 16'h0000, 4'd0, lat, rd, err);
    n_cmp++; if (rd !== 16'h7777) begin n_err++; $display("FAIL post_abort_rd got=%h exp=7777", rd); end
    n_cmp++; if (prot_err !== 1'b1) begin n_err++; $display("FAIL prot_sticky got=%0b exp=1", prot_err); end
  endtask

  task automatic test_mid_reset;
    int lat; logic [15:0] rd; logic err;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'd1; PWDATA = 16'h1111; wait_states = 4'd6;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #3;
    PRESET = 1'b1;
    #1;
    $display("reset asserted during WAIT of write idx1");
    n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL mr_wait_pready got=%0b exp=0", PREADY); end
    n_cmp++; if (prot_err !== 1'b0) begin n_err++; $display("FAIL mr_prot_clr got=%0b exp=0", prot_err); end
    n_cmp++; if (PRDATA !== 16'h0000) begin n_err++; $display("FAIL mr_prdata got=%h exp=0000", PRDATA); end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    n_cmp++; if (regs_o[31:16] !== 16'h0000) begin n_err++; $display("FAIL mr_reg1 got=%h exp=0000", regs_o[31:16]); end
    // Reset while PREADY is high must drop it at once and discard the write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'd1; PWDATA = 16'h2222; wait_states = 4'd0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    n_cmp++; if (PREADY !== 1'b1) begin n_err++; $display("FAIL mr_done_pready_pre got=%0b exp=1", PREADY); end
    PRESET = 1'b1;
    #1;
    $display("reset asserted during DONE of write idx1");
    n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL mr_done_pready got=%0b exp=0", PREADY); end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESET = 1'b0;
    n_cmp++; if (regs_o[31:16] !== 16'h0000) begin n_err++; $display("FAIL mr_done_reg1 got=%h exp=0000", regs_o[31:16]); end
    do_xfer(1'b0, 16'd0, 16'h0000, 4'd2, lat, rd, err);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL mr_after_lat got=%0d exp=3", lat); end
    n_cmp++; if (rd !== 16'hA5B0) begin n_err++; $display("FAIL mr_after_rd got=%h exp=a5b0", rd); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_illegal();
    test_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
